// File: rtl/fxp_div_arb.sv
// fxp_div_arb: round-robin front end that shares one external fixed-latency divider between
// NREQ requesters. One operand pair is accepted per cycle and registered onto the div_* bus.
// A tag pipe {valid, id, dz} runs alongside the divider so each quotient comes back labelled
// with its requester.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   en                   arbitration enable; in-flight operations still complete when low
//   flush                synchronous drop of every in-flight tag
//   req_valid/req_ready  per-requester handshake; req_ready is a one-hot grant
//   req_dividend/divisor flat operand buses, requester i in slice i
//   div_dividend/divisor registered operands to the divider
//   div_out/div_overflow divider result, LAT cycles after its operands change
//   rsp_*                one-cycle tagged result strobe, no back-pressure
//   inflight             accepted but not yet returned operations
module fxp_div_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned WIIA = 8,
  parameter int unsigned WIFA = 8,
  parameter int unsigned WIIB = 8,
  parameter int unsigned WIFB = 8,
  parameter int unsigned WOI  = 8,
  parameter int unsigned WOF  = 8,
  parameter int unsigned LAT  = 18
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            flush,
  input  logic [NREQ-1:0]                 req_valid,
  output logic [NREQ-1:0]                 req_ready,
  input  logic [NREQ*(WIIA+WIFA)-1:0]     req_dividend,
  input  logic [NREQ*(WIIB+WIFB)-1:0]     req_divisor,
  output logic [WIIA+WIFA-1:0]            div_dividend,
  output logic [WIIB+WIFB-1:0]            div_divisor,
  input  logic [WOI+WOF-1:0]              div_out,
  input  logic                            div_overflow,
  output logic                            rsp_valid,
  output logic [$clog2(NREQ)-1:0]         rsp_id,
  output logic [WOI+WOF-1:0]              rsp_quot,
  output logic                            rsp_ovf,
  output logic                            rsp_dz,
  output logic [$clog2(LAT+2):0]          inflight
);

  localparam int unsigned WA  = WIIA + WIFA;
  localparam int unsigned WB  = WIIB + WIFB;
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(LAT + 2) + 1;

  logic [IDW-1:0] ptr_q;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_dz;
  int unsigned    idx;

  logic [WA-1:0]  dvd [NREQ];
  logic [WB-1:0]  dvs [NREQ];

  // Tag pipe: stage 0 loads at the acceptance edge, stage LAT lines up with div_out.
  logic [LAT:0]   tv_q;
  logic [LAT:0]   tdz_q;
  logic [IDW-1:0] tid_q [LAT+1];

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign dvd[g] = req_dividend[g*WA +: WA];
    assign dvs[g] = req_divisor[g*WB +: WB];
  end

  // First valid requester scanning from ptr with wrap.
  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    req_ready = '0;
    if (en && !flush) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr_q) + k) % NREQ;
        if (!gnt_any && req_valid[IDW'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = IDW'(idx);
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_dz = (dvs[gnt_idx] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      inflight     <= '0;
      tv_q         <= '0;
      tdz_q        <= '0;
      for (int unsigned k = 0; k <= LAT; k++) tid_q[k] <= '0;
    end else begin
      if (gnt_any) begin
        ptr_q        <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        div_dividend <= dvd[gnt_idx];
        div_divisor  <= dvs[gnt_idx];
      end
      tv_q     <= flush ? '0 : {tv_q[LAT-1:0], gnt_any};
      tdz_q    <= {tdz_q[LAT-1:0], gnt_dz};
      tid_q[0] <= gnt_idx;
      for (int unsigned k = 1; k <= LAT; k++) tid_q[k] <= tid_q[k-1];
      if (flush) begin
        inflight <= '0;
      end else if (gnt_any && !rsp_valid) begin
        inflight <= inflight + CW'(1);
      end else if (!gnt_any && rsp_valid) begin
        inflight <= inflight - CW'(1);
      end
    end
  end

  // Outputs are gated by the strobe so reset and flush silence them immediately.
  always_comb begin
    rsp_valid = tv_q[LAT] & ~flush;
    rsp_id    = rsp_valid ? tid_q[LAT] : '0;
    rsp_dz    = rsp_valid & tdz_q[LAT];
    rsp_ovf   = rsp_valid & (tdz_q[LAT] | div_overflow);
    rsp_quot  = '0;
    if (rsp_valid) rsp_quot = tdz_q[LAT] ? '1 : div_out;
  end

endmodule

// File: tb/tb_fxp_div_arb.sv
// Self-checking bench for fxp_div_arb: a behavioural divider, a reference arbiter and a
// scoreboard queue of expected responses checked by an independent monitor.
module tb_fxp_div_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 18;
  localparam int W    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 flush = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_dividend = '0;
  logic [NREQ*W-1:0]    req_divisor = '0;
  logic [W-1:0]         div_dividend, div_divisor, div_out, rsp_quot;
  logic                 div_overflow, rsp_valid, rsp_ovf, rsp_dz;
  logic [1:0]           rsp_id;
  logic [$clog2(LAT+2):0] inflight;

  fxp_div_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_out(div_out), .div_overflow(div_overflow),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quot(rsp_quot),
    .rsp_ovf(rsp_ovf), .rsp_dz(rsp_dz), .inflight(inflight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Q8.8 / Q8.8 -> Q8.8, round half away from zero, saturating.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic ovf);
    longint n, d, na, da, r;
    n = longint'($signed(a)) * 256;
    d = longint'($signed(b));
    if (d == 0) begin
      q   = 16'h1234;  // arbitrary garbage the arbiter must override
      ovf = 1'b0;
      return;
    end
    na = (n < 0) ? -n : n;
    da = (d < 0) ? -d : d;
    r  = (2 * na + da) / (2 * da);
    if ((n < 0) != (d < 0)) r = -r;
    ovf = 1'b0;
    if (r > 32767) begin r = 32767; ovf = 1'b1; end
    if (r < -32768) begin r = -32768; ovf = 1'b1; end
    q = W'(r);
  endfunction

  // Behavioural divider: output in cycle m reflects operands seen in cycle m-LAT.
  logic [W-1:0] p_q [LAT];
  logic         p_o [LAT];
  always @(posedge clk) begin
    logic [W-1:0] q;
    logic         o;
    ref_div(div_dividend, div_divisor, q, o);
    p_q[0] <= q;
    p_o[0] <= o;
    for (int k = 1; k < LAT; k++) begin
      p_q[k] <= p_q[k-1];
      p_o[k] <= p_o[k-1];
    end
  end
  assign div_out      = p_q[LAT-1];
  assign div_overflow = p_o[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    logic [W-1:0] quot;
    logic         ovf;
    logic         dz;
    int           due;
  } exp_t;
  exp_t sb[$];

  logic [W-1:0] a_arr [NREQ];
  logic [W-1:0] b_arr [NREQ];
  int mptr = 0;

  // One cycle of stimulus plus reference arbitration.
  task automatic step(input logic [NREQ-1:0] v, input logic e, input logic f);
    logic [NREQ-1:0] g;
    exp_t x;
    int gi;
    @(posedge clk);
    #1;
    req_valid = v;
    en = e;
    flush = f;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*W +: W] = a_arr[i];
      req_divisor[i*W +: W]  = b_arr[i];
    end
    #1;
    chk("inflight", 32'(inflight), 32'(sb.size()));
    g = '0;
    gi = -1;
    if (e && !f) begin
      for (int k = 0; k < NREQ; k++) begin
        if (gi < 0 && v[(mptr + k) % NREQ]) gi = (mptr + k) % NREQ;
      end
    end
    if (gi >= 0) g[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(g));
    if (gi >= 0) begin
      x.id  = gi;
      x.dz  = (b_arr[gi] == 0);
      x.due = cyc + LAT + 1;
      if (x.dz) begin
        x.quot = 16'hFFFF;
        x.ovf  = 1'b1;
      end else begin
        ref_div(a_arr[gi], b_arr[gi], x.quot, x.ovf);
      end
      sb.push_back(x);
      mptr = (gi + 1) % NREQ;
    end
    if (f) sb.delete();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          x = sb.pop_front();
          chk("rsp_time", 32'(cyc), 32'(x.due));
          chk("rsp", {11'd0, 3'(rsp_id), rsp_quot, rsp_ovf, rsp_dz},
              {11'd0, 3'(x.id), x.quot, x.ovf, x.dz});
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        x = sb.pop_front();
        chk("missing_rsp", 32'(rsp_valid), 32'(1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = '0; b_arr[i] = 16'h0100; end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'(0));
    chk("reset_inflight", 32'(inflight), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_div_ops", {div_dividend, div_divisor}, 32'(0));
    rst = 1'b0;

    // Single request from requester 2.
    a_arr[2] = 16'h0080; b_arr[2] = 16'h0180;
    step(4'b0100, 1'b1, 1'b0);
    repeat (LAT + 3) step(4'b0000, 1'b1, 1'b0);

    // All four valid for 8 cycles.
    for (int i = 0; i < NREQ; i++) begin a_arr[i] = 16'hFE80; b_arr[i] = 16'hFC80; end
    repeat (8) step(4'b1111, 1'b1, 1'b0);
    repeat (LAT + 3) step(4'b0000, 1'b1, 1'b0);

    // Divide by zero from requester 1; it also leaves ptr at 2.
    b_arr[1] = 16'h0000;
    step(4'b0010, 1'b1, 1'b0);
    b_arr[1] = 16'h0200;
    // Requesters 1 and 3 with ptr at 2.
    repeat (3) step(4'b1010, 1'b1, 1'b0);
    repeat (LAT + 3) step(4'b0000, 1'b1, 1'b0);

    // Flush five cycles after eight acceptances, then a normal request.
    repeat (8) step(4'b1111, 1'b1, 1'b0);
    repeat (4) step(4'b0000, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    repeat (LAT + 3) step(4'b0000, 1'b1, 1'b0);

    // Reset with six operations in flight.
    repeat (6) step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("rst_outputs", {13'd0, rsp_valid, rsp_ovf, rsp_dz, rsp_quot},
        32'(0));
    chk("rst_state", {6'd0, div_dividend, div_divisor[W-1:6], inflight[3:0]}, 32'(0));
    sb.delete();
    mptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b1111, 1'b1, 1'b0);
    repeat (LAT + 3) step(4'b0000, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = W'($urandom);
        b_arr[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end
      step(NREQ'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0));
    end
    repeat (LAT + 4) step(4'b0000, 1'b1, 1'b0);
    chk("drained", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fxp_div_arb.md
Name: fxp_div_arb

Overview:
- Shares one `fxp_div_pipe` instance between NREQ independent requesters using round-robin arbitration.
- Accepts at most one divide per cycle, registers the operands into the divider, and carries the requester ID and a divide-by-zero flag alongside the fixed-latency pipe.
- Returns each quotient tagged with the ID of the requester that issued it.
- Sits between the fixed-point datapath clients and the shared divider. The divider instance is external and connects through the `div_*` ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIIA, 8, dividend integer bits.
- WIFA, 8, dividend fraction bits.
- WIIB, 8, divisor integer bits.
- WIFB, 8, divisor fraction bits.
- WOI, 8, quotient integer bits.
- WOF, 8, quotient fraction bits.
- LAT, 18, cycles from divider operand change to divider output. Must equal the latency of the connected divider.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  arbitration enable. When low, no new grants are made; in-flight operations complete.
- flush  in  1  synchronous. Drops all in-flight tags.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant. A transfer occurs when `req_valid[i] & req_ready[i]`.
- req_dividend  in  NREQ*(WIIA+WIFA)  flat bus; requester i occupies slice i.
- req_divisor  in  NREQ*(WIIB+WIFB)  flat bus; requester i occupies slice i.
- div_dividend  out  WIIA+WIFA  to divider.
- div_divisor  out  WIIB+WIFB  to divider.
- div_out  in  WOI+WOF  from divider.
- div_overflow  in  1  from divider.
- rsp_valid  out  1  one-cycle result strobe. Cannot be back-pressured.
- rsp_id  out  clog2(NREQ)  requester that owns the result.
- rsp_quot  out  WOI+WOF  quotient.
- rsp_ovf  out  1  divider overflow flag.
- rsp_dz  out  1  divisor was zero.
- inflight  out  clog2(LAT+2)+1  number of accepted but not yet returned operations.

Behaviour:
- Arbitration (combinational):
  - Round-robin pointer `ptr`, reset value 0.
  - When en=1 and flush=0, req_ready has exactly one bit set: the first i with req_valid[i]=1, scanning ptr, ptr+1, … with wrap modulo NREQ.
  - req_ready is all-zero when no request is valid, when en=0, or when flush=1.
- Pointer update: on each grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Issue stage:
  - On a grant, div_dividend and div_divisor register the granted operands.
  - With no grant they hold their previous value; the divider output for those cycles is ignored.
  - Reset value of both: 0.
- Tag pipe:
  - LAT+1 stage shift register of {valid, id, dz}.
  - Stage 0 loads {grant, granted index, divisor==0} every cycle.
  - The output stage is aligned with div_out.
- Response timing:
  - rsp_valid is high exactly LAT+1 cycles after the acceptance edge, for one cycle.
  - rsp_quot = div_out, rsp_ovf = div_overflow, rsp_id and rsp_dz come from the tag pipe.
  - When rsp_dz=1, rsp_quot is forced to all-ones and rsp_ovf=1, regardless of what the divider produced.
- Throughput: one acceptance per cycle sustained. Responses return in acceptance order.
- inflight:
  - +1 on a grant, -1 on rsp_valid, unchanged when both occur in the same cycle.
  - Never exceeds LAT+1.
- flush: clears all tag valid bits on the next edge. No rsp_valid for any operation accepted before or during the flush cycle. inflight <= 0. ptr holds.
- Reset: asserting rst at any time, including mid-operation, immediately clears:
  - all tags and inflight;
  - ptr, div_dividend, div_divisor;
  - rsp_valid, rsp_id, rsp_quot, rsp_ovf, rsp_dz.
  In-flight results are dropped. The first grant after release goes to requester 0 if it is valid.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,NREQ-1,0,…. No requester waits more than NREQ-1 cycles while en=1.
- Simultaneous events:
  - A grant and an expiring response in the same cycle are both honoured.
  - A grant together with flush=1 cannot occur, because req_ready is forced to zero during flush.

Test Plan:
- Single requester 2: dividend 0x0080, divisor 0x0180, ROUND=1 divider → rsp_valid at acceptance+LAT+1, rsp_id=2, rsp_quot=0x0055 (0.332), rsp_ovf=0, rsp_dz=0.
- All four requesters valid for 8 cycles: requester i sends dividend 0xFE80 and divisor 0xFC80 → grants 0,1,2,3,0,1,2,3; eight consecutive responses with IDs in the same order, each rsp_quot=0x006E (0.430); inflight peaks at 8.
- Divisor 0x0000 from requester 1 → rsp_dz=1, rsp_ovf=1, rsp_quot=0xFFFF, rsp_id=1.
- Requesters 1 and 3 valid, ptr=2 → grant 3 first, then 1, then 3; requester 0 is never granted.
- Eight operations accepted, flush asserted 5 cycles later → no rsp_valid ever for them; inflight=0 the cycle after flush; a new request afterwards returns normally.
- rst pulsed while 6 operations are in flight → all outputs 0 immediately; no responses after release; inflight=0; the first grant after release goes to requester 0.
